// File: rtl/mem_if_pkg.sv
// ----------------------------------------------------------------------------
// mem_if_pkg
//   Shared definitions for the external async-SRAM-style responder:
//   FSM state encoding, default bus widths and access-latency bounds.
// ----------------------------------------------------------------------------
package mem_if_pkg;

  // Default pin-interface widths.
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH_LOG2 = 10;

  // Legal range of the programmable read latency, in clock cycles.
  localparam int ACCESS_LAT_MIN = 1;
  localparam int ACCESS_LAT_MAX = 15;

  // Wide enough to hold ACCESS_LAT_MAX - 1.
  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RD_WAIT   = 2'b01,
    RD_DRIVE  = 2'b10,
    WR_ACTIVE = 2'b11
  } state_e;

endpackage

// File: rtl/sram_word_array.sv
// ----------------------------------------------------------------------------
// sram_word_array
//   Single-port word array: synchronous write, registered read.
//   The read register samples the array every cycle at 'addr'; a write and
//   a read in the same cycle return the old word.
// Ports:
//   clk    in   clock
//   we     in   write enable (word-wide, no byte enables)
//   addr   in   word address, DEPTH_LOG2 bits
//   wdata  in   write data
//   rdata  out  registered read data
// ----------------------------------------------------------------------------
module sram_word_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    rdata_d = mem_q[addr];
  end

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // control flops around it are reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ext_sram_responder.sv
// ----------------------------------------------------------------------------
// ext_sram_responder
//   Device-side responder for an async-SRAM-style pin interface. Behaves as
//   a word-addressed memory with programmable read latency. All strobes are
//   sampled on posedge clk and every output is registered, so there is no
//   combinational path from pins to pins. The bidirectional data bus is split
//   into in/out/enable; the parent owns the tri-state buffer.
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   mem_cs_n      in   chip select, active low
//   mem_we_n      in   write strobe, active low
//   mem_oe_n      in   output enable, active low
//   mem_addr      in   word address
//   mem_data_in   in   bus value (write data)
//   mem_data_out  out  read data to drive onto the bus
//   mem_data_oe   out  1 = responder drives the bus
//   busy          out  1 while an access is in progress
//   err_oob       out  pulse: access above the implemented depth
//   err_proto     out  pulse: write and output enable both low
// ----------------------------------------------------------------------------
module ext_sram_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int ACCESS_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_cs_n,
  input  logic                  mem_we_n,
  input  logic                  mem_oe_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_data_oe,
  output logic                  busy,
  output logic                  err_oob,
  output logic                  err_proto
);

  // Counter preload, clamped into the legal latency range.
  localparam int LAT_LOAD = (ACCESS_LAT < ACCESS_LAT_MIN) ? ACCESS_LAT_MIN - 1 :
                            (ACCESS_LAT > ACCESS_LAT_MAX) ? ACCESS_LAT_MAX - 1 :
                                                            ACCESS_LAT - 1;

  state_e                  state_q,    state_d;
  logic [DEPTH_LOG2-1:0]   addr_q,     addr_d;
  logic                    oob_q,      oob_d;
  logic [CNT_WIDTH-1:0]    cnt_q,      cnt_d;
  logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    data_oe_q,  data_oe_d;
  logic                    busy_q,     busy_d;
  logic                    err_oob_q,  err_oob_d;
  logic                    err_proto_q, err_proto_d;

  logic                    addr_hi_nz;
  logic                    arr_commit;
  logic                    arr_we;
  logic [DEPTH_LOG2-1:0]   arr_addr;
  logic [DATA_WIDTH-1:0]   arr_rdata;

  // Any address bit above the implemented depth marks the access out of range.
  if (ADDR_WIDTH > DEPTH_LOG2) begin : g_oob
    assign addr_hi_nz = |mem_addr[ADDR_WIDTH-1:DEPTH_LOG2];
  end else begin : g_no_oob
    assign addr_hi_nz = 1'b0;
  end

  // In IDLE the array looks at the live pins so a read started at edge E has
  // its word ready one edge later; during an access it stays on addr_q.
  assign arr_addr = (state_q == IDLE) ? mem_addr[DEPTH_LOG2-1:0] : addr_q;

  // A reset on the commit edge must not let the pending write through.
  assign arr_we = arr_commit && !rst;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    oob_d       = oob_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    err_oob_d   = 1'b0;
    err_proto_d = 1'b0;
    arr_commit  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!mem_cs_n && (!mem_we_n || !mem_oe_n)) begin
          addr_d    = mem_addr[DEPTH_LOG2-1:0];
          oob_d     = addr_hi_nz;
          err_oob_d = addr_hi_nz;
          if (!mem_we_n) begin
            // Write wins when both strobes are low; flag the conflict.
            state_d     = WR_ACTIVE;
            wdata_d     = mem_data_in;
            err_proto_d = !mem_oe_n;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_WIDTH'(LAT_LOAD);
          end
        end
      end

      RD_WAIT: begin
        if (mem_cs_n || mem_oe_n) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          data_out_d = oob_q ? '0 : arr_rdata;
          data_oe_d  = 1'b1;
          state_d    = RD_DRIVE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end

      RD_DRIVE: begin
        if (mem_cs_n || mem_oe_n) begin
          data_oe_d = 1'b0;
          state_d   = IDLE;
        end else if (!mem_we_n) begin
          data_oe_d   = 1'b0;
          state_d     = IDLE;
          err_proto_d = 1'b1;
        end
      end

      WR_ACTIVE: begin
        if (!mem_cs_n && !mem_we_n) begin
          wdata_d = mem_data_in;
        end else begin
          arr_commit = !oob_q;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      oob_q       <= 1'b0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_oob_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      oob_q       <= oob_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      err_oob_q   <= err_oob_d;
      err_proto_q <= err_proto_d;
    end
  end

  sram_word_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign mem_data_out = data_out_q;
  assign mem_data_oe  = data_oe_q;
  assign busy         = busy_q;
  assign err_oob      = err_oob_q;
  assign err_proto    = err_proto_q;

endmodule

// File: tb/tb_ext_sram_responder.sv
// ----------------------------------------------------------------------------
// tb_ext_sram_responder
//   Two responders share one set of pins: dut1 with ACCESS_LAT=1 and dut4
//   with ACCESS_LAT=4. Expected values come from a word-addressed memory
//   model and the latency rule "driven from edge E+ACCESS_LAT onward".
// ----------------------------------------------------------------------------
module tb_ext_sram_responder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DL = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs_n = 1'b1;
  logic          we_n = 1'b1;
  logic          oe_n = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din  = '0;

  logic [DW-1:0] dout1, dout4;
  logic          doe1, doe4, busy1, busy4;
  logic          eoob1, eoob4, eproto1, eproto4;

  int total = 0;
  int bad   = 0;

  // Reference memory: in-range word address -> last committed word.
  logic [DW-1:0] model [int];
  int            written_q [$];

  always #5 clk = ~clk;

  ext_sram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .ACCESS_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .mem_cs_n(cs_n), .mem_we_n(we_n), .mem_oe_n(oe_n),
    .mem_addr(addr), .mem_data_in(din), .mem_data_out(dout1), .mem_data_oe(doe1),
    .busy(busy1), .err_oob(eoob1), .err_proto(eproto1)
  );

  ext_sram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .ACCESS_LAT(4)) dut4 (
    .clk(clk), .rst(rst), .mem_cs_n(cs_n), .mem_we_n(we_n), .mem_oe_n(oe_n),
    .mem_addr(addr), .mem_data_in(din), .mem_data_out(dout4), .mem_data_oe(doe4),
    .busy(busy4), .err_oob(eoob4), .err_proto(eproto4)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  // Outputs settle on posedge; sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus();
    cs_n = 1'b1;
    we_n = 1'b1;
    oe_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check_bit({tag, "_oe1"},    doe1,    1'b0);
    check_bit({tag, "_oe4"},    doe4,    1'b0);
    check_bit({tag, "_busy1"},  busy1,   1'b0);
    check_bit({tag, "_busy4"},  busy4,   1'b0);
    check_bit({tag, "_oob1"},   eoob1,   1'b0);
    check_bit({tag, "_proto1"}, eproto1, 1'b0);
  endtask

  function automatic bit is_oob(input logic [AW-1:0] a);
    return (a >> DL) != 0;
  endfunction

  // Write strobe held for 'hold' edges; the last held edge carries d_last.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d_first,
                          input logic [DW-1:0] d_last, input int hold, input bit proto);
    bit oob;
    oob  = is_oob(a);
    addr = a;
    cs_n = 1'b0;
    we_n = 1'b0;
    oe_n = proto ? 1'b0 : 1'b1;
    for (int k = 1; k <= hold; k++) begin
      din = (k == hold) ? d_last : d_first;
      tick();
      check_bit("wr_busy1",  busy1,   1'b1);
      check_bit("wr_oe1",    doe1,    1'b0);
      check_bit("wr_oe4",    doe4,    1'b0);
      check_bit("wr_oob1",   eoob1,   (k == 1) && oob);
      check_bit("wr_proto1", eproto1, (k == 1) && proto);
      check_bit("wr_proto4", eproto4, (k == 1) && proto);
      addr = $urandom();  // must be ignored once the access has started
    end
    release_bus();
    din = $urandom();
    tick();
    check_idle("wr_end");
    if (!oob) begin
      if (!model.exists(int'(a))) written_q.push_back(int'(a));
      model[int'(a)] = d_last;
    end
  endtask

  // Read strobe held for 'hold' edges; edge k=1 is the sampling edge E.
  task automatic do_read(input logic [AW-1:0] a, input int hold);
    bit            oob;
    logic [DW-1:0] exp;
    oob  = is_oob(a);
    exp  = oob ? '0 : model[int'(a)];
    addr = a;
    cs_n = 1'b0;
    we_n = 1'b1;
    oe_n = 1'b0;
    for (int k = 1; k <= hold; k++) begin
      tick();
      check_bit("rd_oe1",   doe1,  (k - 1) >= 1);
      check_bit("rd_oe4",   doe4,  (k - 1) >= 4);
      check_bit("rd_busy1", busy1, 1'b1);
      check_bit("rd_busy4", busy4, 1'b1);
      check_bit("rd_oob1",  eoob1, (k == 1) && oob);
      check_bit("rd_oob4",  eoob4, (k == 1) && oob);
      if ((k - 1) >= 1) check("rd_data1", dout1, exp);
      if ((k - 1) >= 4) check("rd_data4", dout4, exp);
      addr = $urandom();
    end
    release_bus();
    tick();
    check_idle("rd_end");
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    // Reset.
    release_bus();
    rst = 1'b1;
    tick();
    tick();
    check("rst_dout1", dout1, '0);
    check("rst_dout4", dout4, '0);
    check_idle("rst");
    check_bit("rst_proto4", eproto4, 1'b0);
    check_bit("rst_oob4",   eoob4,   1'b0);
    rst = 1'b0;
    tick();

    // Write then read, latency 1 (dut4 aborts in RD_WAIT).
    do_write(32'h010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 1'b0);
    do_read(32'h010, 4);

    // Latency 4: full read, then an abort after 2 edges.
    do_write(32'h3FF, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 1'b0);
    do_read(32'h3FF, 7);
    do_read(32'h3FF, 2);

    // Out of range: the write must not alias onto word 0.
    do_write(32'h000, 32'hCAFE_F00D, 32'hCAFE_F00D, 2, 1'b0);
    do_write(32'h400, 32'h1234_5678, 32'h1234_5678, 2, 1'b0);
    do_read(32'h000, 5);
    do_read(32'h400, 6);

    // Write and output enable both low: write performed, bus never driven.
    do_write(32'h020, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 2, 1'b1);
    do_read(32'h020, 3);

    // Reset on the commit edge of a write: old word survives.
    do_write(32'h030, 32'h2222_2222, 32'h2222_2222, 2, 1'b0);
    addr = 32'h030;
    din  = 32'h1111_1111;
    cs_n = 1'b0;
    we_n = 1'b0;
    tick();
    tick();
    check_bit("rstwr_busy1", busy1, 1'b1);
    rst = 1'b1;
    release_bus();
    tick();
    check_idle("rstwr");
    rst = 1'b0;
    tick();
    do_read(32'h030, 2);

    // Reset while driving: bus released on the reset edge.
    addr = 32'h010;
    cs_n = 1'b0;
    oe_n = 1'b0;
    tick();
    tick();
    tick();
    check_bit("rstrd_oe1_before", doe1, 1'b1);
    check("rstrd_data1_before", dout1, 32'hDEAD_BEEF);
    rst = 1'b1;
    tick();
    check("rstrd_dout1", dout1, '0);
    check_idle("rstrd");
    rst = 1'b0;
    release_bus();
    tick();

    // Last data sampled with the strobe low wins.
    do_write(32'h040, 32'h0000_0001, 32'h0000_0002, 3, 1'b0);
    do_read(32'h040, 2);

    // Write strobe during RD_DRIVE: bus released with a protocol error.
    addr = 32'h010;
    cs_n = 1'b0;
    oe_n = 1'b0;
    tick();
    tick();
    check_bit("rdwe_oe1_before", doe1, 1'b1);
    we_n = 1'b0;
    tick();
    check_bit("rdwe_oe1",    doe1,    1'b0);
    check_bit("rdwe_proto1", eproto1, 1'b1);
    check_bit("rdwe_proto4", eproto4, 1'b0);
    release_bus();
    tick();
    check_idle("rdwe_end");

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0)
        a = {22'($urandom_range(1, 4194303)), 10'($urandom_range(0, 1023))};
      else
        a = 32'($urandom_range(0, 1023));
      d = $urandom();
      if ($urandom_range(0, 1) == 0 || written_q.size() == 0) begin
        do_write(a, $urandom(), d, $urandom_range(1, 4), $urandom_range(0, 5) == 0);
      end else begin
        if (!is_oob(a)) a = 32'(written_q[$urandom_range(0, written_q.size() - 1)]);
        do_read(a, $urandom_range(1, 7));
      end
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_sram_responder.md
Name: ext_sram_responder

Overview:
- Synthesizable responder for the external async-SRAM-style pin interface: mem_cs_n, mem_we_n, mem_oe_n, mem_addr, mem_data.
- Sits on the device side of those pins and behaves as a word-addressed memory with programmable access latency.
- Used as the on-FPGA stand-in memory and as the loopback target for the external memory interface.
- The bidirectional data bus is split into in/out/enable; the top level owns the tri-state buffer.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr.
- DATA_WIDTH, 32, width of the data bus and of each word.
- DEPTH_LOG2, 10, log2 of the number of words (1024).
- ACCESS_LAT, 1, cycles from the strobe being sampled active to read data being driven. Legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- mem_cs_n  in  1  chip select, active low.
- mem_we_n  in  1  write strobe, active low.
- mem_oe_n  in  1  output enable, active low.
- mem_addr  in  ADDR_WIDTH  word address.
- mem_data_in  in  DATA_WIDTH  bus value seen by the responder (write data).
- mem_data_out  out  DATA_WIDTH  read data to drive onto the bus.
- mem_data_oe  out  1  high = responder drives the bus.
- busy  out  1  high whenever state != IDLE.
- err_oob  out  1  one-cycle pulse: access to an address with nonzero bits above DEPTH_LOG2.
- err_proto  out  1  one-cycle pulse: we_n and oe_n both low at access start.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; mem_data_oe=0; mem_data_out=0; busy=0; err_oob=0; err_proto=0; counter=0.
  - Array contents are not cleared.
  - Reset mid-access: the bus is released on that edge and no pending write is committed.
- Strobes are sampled at posedge only; no combinational path from inputs to outputs.
- Access start, in IDLE with cs_n=0:
  - Latch mem_addr into addr_q; later changes of mem_addr are ignored until return to IDLE.
  - If we_n=0, go to WR_ACTIVE. Write takes priority; if oe_n is also 0, pulse err_proto.
  - Else if oe_n=0, go to RD_WAIT with counter=ACCESS_LAT-1 and issue the array read.
  - cs_n=0 with both we_n and oe_n high: stay IDLE.
  - Out of range (addr bits above DEPTH_LOG2 nonzero): pulse err_oob. Reads return all-zero. Writes are dropped.
- RD_WAIT:
  - counter==0: load mem_data_out from the array data, set mem_data_oe=1, go to RD_DRIVE.
  - Otherwise decrement the counter.
  - cs_n or oe_n sampled high: abort to IDLE; the bus is never driven.
- Read latency: with the strobe first sampled at edge E, mem_data_oe rises at edge E+ACCESS_LAT. Default 1 meets a controller that samples 3 edges after asserting strobes.
- RD_DRIVE:
  - Hold mem_data_out and mem_data_oe=1 while cs_n=0 and oe_n=0.
  - On the edge either is sampled high: mem_data_oe=0 and go to IDLE.
  - If we_n is sampled low while in RD_DRIVE: mem_data_oe=0, go to IDLE, pulse err_proto.
- WR_ACTIVE:
  - Each cycle with cs_n=0 and we_n=0: capture mem_data_in into wdata_q.
  - On the edge where cs_n or we_n is sampled high: commit wdata_q to array[addr_q] (unless out of range), go to IDLE.
  - The last data sampled while the strobe was low wins.
  - mem_data_oe stays 0 throughout.
- Back-to-back: one IDLE cycle is mandatory between accesses. A strobe held low through the return to IDLE starts a new access on the next edge.
- The array is word-only; there are no byte enables.

Decomposition:
- Package mem_if_pkg holds:
  - state encoding constants IDLE=2'b00, RD_WAIT=2'b01, RD_DRIVE=2'b10, WR_ACTIVE=2'b11;
  - default ADDR_WIDTH/DATA_WIDTH;
  - ACCESS_LAT bounds.
- One sub-module, sram_word_array: single port, synchronous write, registered read, parameters DATA_WIDTH and DEPTH_LOG2.

Test Plan:
- Write then read, ACCESS_LAT=1:
  - Write 0xDEADBEEF to 0x010, strobe held 3 cycles.
  - Read 0x010: mem_data_oe rises 1 edge after the strobe is sampled, and mem_data_out=0xDEADBEEF until oe_n rises.
  - busy falls on the same edge.
- Latency sweep ACCESS_LAT=4:
  - Read 0x3FF.
  - Check: mem_data_oe low for 3 edges, high at the 4th.
  - Check: aborting with cs_n high after 2 cycles leaves mem_data_oe at 0 throughout.
- Out of range:
  - Write 0x12345678 to 0x400 → err_oob pulses once and array[0x000] is unchanged.
  - Read 0x400 → data 0x00000000 with err_oob pulse.
- Protocol error:
  - cs_n=0, we_n=0, oe_n=0 with data 0xA5A5A5A5 at 0x020 → err_proto pulse, write performed, mem_data_oe never 1.
  - Readback returns 0xA5A5A5A5.
- Reset mid-op:
  - Assert rst during WR_ACTIVE (data 0x11111111 to 0x030, previously 0x22222222) → readback 0x22222222.
  - Assert rst during RD_DRIVE → mem_data_oe=0 on the reset edge.
- Last-data-wins:
  - mem_data_in changes from 0x1 to 0x2 while we_n is low; we_n rises after 0x2 is sampled → readback 0x00000002.
